alu_src_a_stage: RTL

//  Registered, parametrised successor to the ALU operand-A source mux. It selects

---
 rtl/alu_src_a_stage_if.sv | 41 ++++
 rtl/alu_src_a_stage.sv | 101 ++++++++++
 2 files changed

// File: rtl/alu_src_a_stage_if.sv
// alu_src_a_stage_if
//   Bundles the operand request, constant-table write, flush and output
//   handshake signals of alu_src_a_stage.
//   master : upstream/downstream environment (drives requests, consumes operand)
//   slave  : the stage itself
//   Request side : InValid, InReady, SrcSel, ReadA, FwdExData, FwdMemData
//   Table write  : ConstWrEn, ConstWrIdx, ConstWrData
//   Control      : Flush
//   Output side  : OutValid, OutReady, ALUInputA, SelError
interface alu_src_a_stage_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned SEL_W = 3,
  parameter int unsigned IDX_W = 2
);
  logic             InValid;
  logic             InReady;
  logic [SEL_W-1:0] SrcSel;
  logic [W-1:0]     ReadA;
  logic [W-1:0]     FwdExData;
  logic [W-1:0]     FwdMemData;
  logic             ConstWrEn;
  logic [IDX_W-1:0] ConstWrIdx;
  logic [W-1:0]     ConstWrData;
  logic             Flush;
  logic             OutReady;
  logic             OutValid;
  logic [W-1:0]     ALUInputA;
  logic             SelError;

  modport master (
    output InValid, SrcSel, ReadA, FwdExData, FwdMemData,
           ConstWrEn, ConstWrIdx, ConstWrData, Flush, OutReady,
    input  InReady, OutValid, ALUInputA, SelError
  );

  modport slave (
    input  InValid, SrcSel, ReadA, FwdExData, FwdMemData,
           ConstWrEn, ConstWrIdx, ConstWrData, Flush, OutReady,
    output InReady, OutValid, ALUInputA, SelError
  );
endinterface

// File: rtl/alu_src_a_stage.sv
// alu_src_a_stage
//   Registered ALU operand-A source mux. Selects between the register-file
//   read, the EX and MEM forwarding paths, zero, and a writable constant
//   table, and holds the result in a one-entry pipeline register with a
//   valid/ready handshake (absorbs stalls, drops the held operand on flush).
//   Clk   : clock, rising edge
//   Reset : synchronous, active high
//   bus   : alu_src_a_stage_if slave (request, table write, flush, output)
//   SrcSel encoding: 0=ReadA 1=FwdEx 2=FwdMem 3=zero 4+k=const[k];
//   anything beyond the table yields 0 and sets the sticky SelError on accept.
module alu_src_a_stage #(
  parameter int unsigned W          = 8,
  parameter int unsigned NUM_CONST  = 4,
  parameter int unsigned CONST0_RST = 64,
  parameter int unsigned SEL_W      = 3
) (
  input  logic                Clk,
  input  logic                Reset,
  alu_src_a_stage_if.slave    bus
);

  localparam logic [W-1:0] CONST0_VAL = CONST0_RST[W-1:0];

  typedef enum logic {EMPTY, FULL} validState_e;

  validState_e          state;
  logic [W-1:0]         aluA;
  logic                 selErr;
  logic [W-1:0]         constTab [NUM_CONST];
  logic [NUM_CONST-1:0] wrHit;
  logic [W-1:0]         selValue;
  logic                 selOutOfRange;
  logic                 outValid;
  logic                 inReady;
  logic                 accept;

  assign outValid = (state == FULL);
  assign inReady  = !outValid || bus.OutReady;
  assign accept   = bus.InValid && inReady && !bus.Flush;

  // An index beyond the table never matches any entry, so such writes vanish.
  always_comb begin
    wrHit = '0;
    for (int unsigned k = 0; k < NUM_CONST; k++) begin
      wrHit[k] = bus.ConstWrEn && (32'(bus.ConstWrIdx) == k);
    end
  end

  // Constant entries are write-through: a same-cycle write to the selected
  // entry supplies the new data rather than the stored value.
  always_comb begin
    selValue      = '0;
    selOutOfRange = 1'b0;
    case (bus.SrcSel)
      SEL_W'(0): selValue = bus.ReadA;
      SEL_W'(1): selValue = bus.FwdExData;
      SEL_W'(2): selValue = bus.FwdMemData;
      SEL_W'(3): selValue = '0;
      default: begin
        selOutOfRange = 1'b1;
        for (int unsigned k = 0; k < NUM_CONST; k++) begin
          if (32'(bus.SrcSel) == k + 4) begin
            selOutOfRange = 1'b0;
            selValue      = wrHit[k] ? bus.ConstWrData : constTab[k];
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= EMPTY;
      aluA   <= '0;
      selErr <= 1'b0;
      for (int unsigned k = 0; k < NUM_CONST; k++) begin
        constTab[k] <= (k == 0) ? CONST0_VAL : '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_CONST; k++) begin
        if (wrHit[k]) constTab[k] <= bus.ConstWrData;
      end
      // Flush beats accept and hold; the operand value itself is left alone.
      if (bus.Flush) begin
        state <= EMPTY;
      end else if (accept) begin
        state <= FULL;
        aluA  <= selValue;
        if (selOutOfRange) selErr <= 1'b1;
      end else if (outValid && bus.OutReady) begin
        state <= EMPTY;
      end
    end
  end

  assign bus.InReady   = inReady;
  assign bus.OutValid  = outValid;
  assign bus.ALUInputA = aluA;
  assign bus.SelError  = selErr;

endmodule
